// File: rtl/vga_row_reveal_ctrl_if.sv
// Control/status bundle of the row-reveal VGA controller.
// The master drives the control inputs; the slave (the controller) drives raster and status.
interface vga_row_reveal_ctrl_if;
  logic       ena;
  logic       start;
  logic       pause;
  logic [1:0] speed;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       frame_tick;
  logic [9:0] reveal_row;
  logic       row_visible;
  logic [1:0] state;
  logic       busy;

  modport master (
    output ena, start, pause, speed,
    input  hsync, vsync, display_on, hpos, vpos, frame_tick,
           reveal_row, row_visible, state, busy
  );

  modport slave (
    input  ena, start, pause, speed,
    output hsync, vsync, display_on, hpos, vpos, frame_tick,
           reveal_row, row_visible, state, busy
  );
endinterface

// File: rtl/vga_row_reveal_ctrl.sv
// VGA raster/sync generator with a frame-paced FSM that reveals, holds and wipes
// the picture one band of rows per frame.
module vga_row_reveal_ctrl #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_row_reveal_ctrl_if.slave  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] ROW_MAX  = 11'(V_ACTIVE);
  localparam logic [7:0]  HOLD_LIM = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    HOLD   = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  logic [9:0]  hpos_q, hpos_d;
  logic [9:0]  vpos_q, vpos_d;
  logic [9:0]  reveal_q, reveal_d;
  logic [7:0]  hold_q, hold_d;
  state_e      state_q, state_d;

  logic        tick;
  logic        display_on;
  logic [10:0] step;
  logic [10:0] sum;
  logic [10:0] diff;

  assign tick       = (hpos_q == '0) && (vpos_q == V_VIS);
  assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

  always_comb begin
    hpos_d   = (hpos_q == H_LAST) ? '0 : hpos_q + 10'd1;
    vpos_d   = vpos_q;
    if (hpos_q == H_LAST) begin
      vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
    end

    // 11-bit arithmetic so the saturating add/sub cannot wrap.
    step     = 11'd1 << bus.speed;
    sum      = {1'b0, reveal_q} + step;
    diff     = {1'b0, reveal_q} - step;

    state_d  = state_q;
    reveal_d = reveal_q;
    hold_d   = hold_q;

    if (!bus.pause) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) state_d = REVEAL;
        end
        REVEAL: begin
          if (tick) begin
            if (sum >= ROW_MAX) begin
              reveal_d = ROW_MAX[9:0];
              state_d  = HOLD;
              hold_d   = '0;
            end else begin
              reveal_d = sum[9:0];
            end
          end
        end
        HOLD: begin
          if (tick) begin
            hold_d = hold_q + 8'd1;
            if (hold_d == HOLD_LIM) state_d = CLEAR;
          end
        end
        CLEAR: begin
          if (tick) begin
            if ({1'b0, reveal_q} <= step) begin
              reveal_d = '0;
              state_d  = IDLE;
            end else begin
              reveal_d = diff[9:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q   <= '0;
      vpos_q   <= '0;
      reveal_q <= '0;
      hold_q   <= '0;
      state_q  <= IDLE;
    end else if (bus.ena) begin
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      reveal_q <= reveal_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
    end
  end

  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.hsync       = !((hpos_q >= HS_BEG) && (hpos_q < HS_END));
  assign bus.vsync       = !((vpos_q >= VS_BEG) && (vpos_q < VS_END));
  assign bus.display_on  = display_on;
  assign bus.frame_tick  = tick;
  assign bus.reveal_row  = reveal_q;
  assign bus.row_visible = display_on && (vpos_q < reveal_q);
  assign bus.state       = state_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/vga_row_reveal_ctrl.md
# vga_row_reveal_ctrl

Frame-paced controller for the row-by-row VGA display. It owns the 640x480@60 Hz raster counters and sync generation, driven by a 25.175 MHz pixel clock, and runs a small FSM. The FSM reveals the picture one band of rows per frame, holds the full picture, then wipes it back out. The pixel pattern logic sits downstream and consumes `hpos`, `vpos` and `row_visible`. The top-level maps `hsync`/`vsync` to `uo_out` pins.

## Interface
- `H_ACTIVE` = 640, `H_FP` = 16, `H_SYNC` = 96, `H_BP` = 48: horizontal timing. Line is 800 clocks.
- `V_ACTIVE` = 480, `V_FP` = 10, `V_SYNC` = 2, `V_BP` = 33: vertical timing. Frame is 525 lines.
- `HOLD_FRAMES` = 60: number of frame ticks spent in HOLD (range 1..255).

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset. Synchronous, active-low. One clock, `clk`, for the whole block.
- `ena` in 1: global enable. While low, every register holds its value.
- `start` in 1: request to begin a reveal. Sampled every cycle; acted on only in IDLE.
- `pause` in 1: freezes the FSM and `reveal_row`. Raster timing keeps running.
- `speed` in 2: rows per frame tick, step = 1 << `speed` (1, 2, 4 or 8).
- `hsync`, `vsync` out 1: active-low syncs.
- `display_on` out 1: high when `hpos` < 640 and `vpos` < 480.
- `hpos`, `vpos` out 10: raster position.
- `frame_tick` out 1: one-cycle pulse at `hpos`==0, `vpos`==480 (start of vblank).
- `reveal_row` out 10: number of rows currently shown (0..480).
- `row_visible` out 1: `display_on` && `vpos` < `reveal_row`.
- `state` out 2: IDLE=0, REVEAL=1, HOLD=2, CLEAR=3.
- `busy` out 1: `state` != IDLE.

## Operation
- Raster counters:
  - `hpos` counts 0..799 and wraps to 0.
  - `vpos` increments when `hpos` wraps, counts 0..524 and wraps.
- Sync windows:
  - `hsync` is low for `hpos` 656..751.
  - `vsync` is low for `vpos` 490..491.
- `hsync`, `vsync`, `display_on`, `frame_tick` and `row_visible` are decoded combinationally from the registered counters and `reveal_row`.
- FSM (transitions take effect at a clock edge when `ena`=1 and `pause`=0):
  - IDLE: when `start`=1, go to REVEAL. `reveal_row` stays 0.
  - REVEAL: on each `frame_tick`, `reveal_row` = min(`reveal_row` + step, 480). On reaching 480 in that same update, go to HOLD and clear `hold_cnt`.
  - HOLD: on each `frame_tick`, `hold_cnt`++. When `hold_cnt` reaches `HOLD_FRAMES`, go to CLEAR.
  - CLEAR: on each `frame_tick`, `reveal_row` = max(`reveal_row` − step, 0). On reaching 0, go to IDLE.
- Boundary and corner cases:
  - `start` outside IDLE is ignored.
  - `start` coinciding with `frame_tick` in IDLE: enter REVEAL with no increment on that tick.
  - `speed` is sampled at each `frame_tick`. Changing it mid-sequence affects only later ticks.
  - Saturation arithmetic uses an 11-bit intermediate. `reveal_row` never exceeds 480 and never underflows.
  - `pause`=1 during a `frame_tick`: that tick is lost, not deferred.
  - `reveal_row` changes only at `frame_tick`, i.e. in vblank, so there is no tearing within a frame.

## Timing
- Reset (`rst_n`=0 at an edge): `hpos`=0, `vpos`=0, `reveal_row`=0, `hold_cnt`=0, `state`=IDLE. After reset the decoded outputs are therefore `hsync`=1, `vsync`=1, `display_on`=1, `frame_tick`=0, `row_visible`=0, `busy`=0.
- Reset mid-operation aborts any state within one edge. Reset has priority over `ena`.
- `start` to `state`=REVEAL: 1 clock.
- First increment of `reveal_row` happens at the next `frame_tick` after entering REVEAL.
- `reveal_row` and `state` update on the edge at which `frame_tick` is high. New values are visible from `hpos`=1, `vpos`=480.
- Periods:
  - Line: 800 clocks.
  - Frame: 420 000 clocks.
  - Full reveal at step s: 480/s ticks.
  - Full cycle: 2·480/s + `HOLD_FRAMES` ticks.

## Test plan
- Reset: hold `rst_n`=0 for 2 clocks with random inputs, then release. Expect `hpos`=`vpos`=0, `hsync`=`vsync`=1, `reveal_row`=0, `state`=0, `busy`=0.
- Raster timing: run 2 frames. Expect:
  - `hsync` low for exactly 96 clocks starting at `hpos`=656, repeating every 800 clocks.
  - `vsync` low for 1600 clocks starting at `vpos`=490.
  - `frame_tick` spaced exactly 420 000 clocks apart.
- Reveal, `speed`=3: pulse `start`. Expect `reveal_row` = 8, 16, … after successive ticks, and `state`=HOLD at the 60th tick with `reveal_row`=480. Check `row_visible`=1 at (`hpos` 0, `vpos` 7) after the first tick and 0 at `vpos` 8.
- Saturation: with `speed`=2, run to `reveal_row`=476, then set `speed`=3. Next tick gives `reveal_row`=480 and `state`=HOLD, not 484.
- Hold/clear with `HOLD_FRAMES`=2, `speed`=3:
  - HOLD exits to CLEAR after exactly 2 ticks.
  - `reveal_row` goes 472, …, 0 over 60 ticks, then `state`=IDLE.
  - `start` pulsed during HOLD is ignored.
- Pause and abort:
  - `pause`=1 across one tick in REVEAL: `reveal_row` is unchanged for that frame.
  - `rst_n`=0 mid-CLEAR: next edge gives `reveal_row`=0 and `state`=IDLE.
  - `ena`=0 for 100 clocks: `hpos` is frozen.
